// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: IDLE -> EXEC -> WB around an external combinational ALU,
// with a small register file, operand forwarding and a host write/debug port.
module alu_issue_ctrl #(
  parameter int N    = 32,
  parameter int REGS = 8,
  localparam int AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  output logic [N-1:0]  alu_r2,
  output logic [N-1:0]  alu_r3,
  output logic [2:0]    alu_op,
  input  logic [N-1:0]  alu_r1,
  output logic          done,
  output logic          done_err,
  output logic [AW-1:0] done_rd,
  output logic [N-1:0]  done_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [N-1:0]  host_wdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  localparam logic [2:0] OP_ERR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  regs_q [REGS];
  logic [N-1:0]  regs_d [REGS];
  logic [N-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          accept, wb_wr, host_wr;
  logic [N-1:0]  fwd_a, fwd_b;

  assign instr_ready = rst_n && (state_q != S_EXEC);
  assign accept      = instr_valid && instr_ready;
  assign wb_wr       = (state_q == S_WB) && (op_q != OP_ERR) && (rd_q != '0);
  assign host_wr     = host_we && (host_waddr != '0);

  // Operand read sees this edge's writes: retiring result beats host write beats file.
  assign fwd_a = (wb_wr && instr_rs == rd_q)         ? res_q      :
                 (host_wr && instr_rs == host_waddr) ? host_wdata : regs_q[instr_rs];
  assign fwd_b = (wb_wr && instr_rt == rd_q)         ? res_q      :
                 (host_wr && instr_rt == host_waddr) ? host_wdata : regs_q[instr_rt];

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    op_d    = op_q;
    rd_d    = rd_q;
    regs_d  = regs_q;

    if (host_wr) regs_d[host_waddr] = host_wdata;
    if (wb_wr)   regs_d[rd_q]       = res_q;

    unique case (state_q)
      S_IDLE, S_WB: begin
        if (accept) begin
          state_d = S_EXEC;
          op_d    = instr_op;
          rd_d    = instr_rd;
          opa_d   = fwd_a;
          opb_d   = fwd_b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        res_d   = alu_r1;
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      regs_q  <= '{default: '0};
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign alu_r2    = opa_q;
  assign alu_r3    = opb_q;
  assign alu_op    = op_q;
  // Gated by rst_n so a reset landing in WB never shows a retire pulse.
  assign done      = rst_n && (state_q == S_WB);
  assign done_err  = done && (op_q == OP_ERR);
  assign done_rd   = rd_q;
  assign done_data = (op_q == OP_ERR) ? '0 : res_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, transaction-level reference model,
// directed literal scenarios followed by randomized traffic.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs, instr_rt;
  logic [31:0] alu_r2, alu_r3, alu_r1;
  logic [2:0]  alu_op;
  logic        done, done_err;
  logic [2:0]  done_rd;
  logic [31:0] done_data;
  logic        host_we;
  logic [2:0]  host_waddr;
  logic [31:0] host_wdata;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.N(32), .REGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_op(alu_op), .alu_r1(alu_r1),
    .done(done), .done_err(done_err), .done_rd(done_rd), .done_data(done_data),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return ~(a | b);
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_r1 = alu_fn(alu_op, alu_r2, alu_r3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction accepted at an edge reads the register file as it
  // stands after that edge's writes, and retires one cycle later.
  logic [31:0] m_regs [8];
  logic        model_ok = 1'b0;
  logic        ex_v, wb_v;
  logic [2:0]  ex_rd, ex_op, wb_rd, wb_op;
  logic [31:0] ex_res, wb_res;
  logic [31:0] last_a, last_b;
  logic [2:0]  last_op;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_regs   = '{default: '0};
        ex_v     = 1'b0;  wb_v   = 1'b0;
        ex_rd    = '0;    ex_op  = '0;  ex_res = '0;
        wb_rd    = '0;    wb_op  = '0;  wb_res = '0;
        last_a   = '0;    last_b = '0;  last_op = '0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (host_we && host_waddr != 3'd0) m_regs[host_waddr] = host_wdata;
        if (wb_v && wb_op != 3'b111 && wb_rd != 3'd0) m_regs[wb_rd] = wb_res;
        wb_v = ex_v; wb_rd = ex_rd; wb_op = ex_op; wb_res = ex_res;
        if (instr_valid && !ex_v) begin
          last_a  = m_regs[instr_rs];
          last_b  = m_regs[instr_rt];
          last_op = instr_op;
          ex_v    = 1'b1;
          ex_rd   = instr_rd;
          ex_op   = instr_op;
          ex_res  = alu_fn(instr_op, last_a, last_b);
        end else begin
          ex_v = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        if (!rst_n) begin
          chk("m_ready_rst", {31'd0, instr_ready}, 32'd0);
          chk("m_done_rst", {31'd0, done}, 32'd0);
        end else begin
          chk("m_ready", {31'd0, instr_ready}, {31'd0, !ex_v});
          chk("m_done", {31'd0, done}, {31'd0, wb_v});
          if (wb_v) begin
            chk("m_done_err", {31'd0, done_err}, {31'd0, wb_op == 3'b111});
            chk("m_done_rd", {29'd0, done_rd}, {29'd0, wb_rd});
            chk("m_done_data", done_data, (wb_op == 3'b111) ? 32'd0 : wb_res);
          end else begin
            chk("m_done_err_idle", {31'd0, done_err}, 32'd0);
          end
        end
        chk("m_alu_r2", alu_r2, last_a);
        chk("m_alu_r3", alu_r3, last_b);
        chk("m_alu_op", {29'd0, alu_op}, {29'd0, last_op});
        chk("m_dbg", dbg_data, m_regs[dbg_addr]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hw(input logic [2:0] a, input logic [31:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic dbg(input string name, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
    instr_rt = '0; host_we = 1'b0; host_waddr = '0; host_wdata = '0; dbg_addr = '0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_data", done_data, 32'd0);
    chk("rst_alu_r2", alu_r2, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // ADD r3 = r1 + r2
    hw(3'd1, 32'd5);
    hw(3'd2, 32'd3);
    issue(3'b010, 3'd3, 3'd1, 3'd2);
    chk("add_exec_done", {31'd0, done}, 32'd0);
    chk("add_exec_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("add_done", {31'd0, done}, 32'd1);
    chk("add_data", done_data, 32'd8);
    chk("add_rd", {29'd0, done_rd}, 32'd3);
    tick();
    dbg("add_r3", 3'd3, 32'd8);

    // SUB r4 then SLT r5 back-to-back
    issue(3'b011, 3'd4, 3'd1, 3'd2);
    instr_valid = 1'b1; instr_op = 3'b110; instr_rd = 3'd5; instr_rs = 3'd2; instr_rt = 3'd1;
    tick();
    chk("sub_done", {31'd0, done}, 32'd1);
    chk("sub_data", done_data, 32'd2);
    tick();
    instr_valid = 1'b0;
    chk("slt_exec_done", {31'd0, done}, 32'd0);
    tick();
    chk("slt_done", {31'd0, done}, 32'd1);
    chk("slt_data", done_data, 32'd1);
    chk("slt_rd", {29'd0, done_rd}, 32'd5);
    tick();
    dbg("sub_r4", 3'd4, 32'd2);
    dbg("slt_r5", 3'd5, 32'd1);

    // Forwarding from a retiring result (stale r3 is 1)
    hw(3'd3, 32'd1);
    issue(3'b010, 3'd3, 3'd1, 3'd2);
    tick();
    chk("fwd_first_data", done_data, 32'd8);
    issue(3'b010, 3'd6, 3'd3, 3'd3);
    tick();
    chk("fwd_data", done_data, 32'd16);
    tick();
    dbg("fwd_r6", 3'd6, 32'd16);

    // Rejected opcode, then write to r0
    issue(3'b111, 3'd2, 3'd1, 3'd1);
    tick();
    chk("err_done", {31'd0, done}, 32'd1);
    chk("err_flag", {31'd0, done_err}, 32'd1);
    chk("err_data", done_data, 32'd0);
    tick();
    dbg("err_r2", 3'd2, 32'd3);
    issue(3'b010, 3'd0, 3'd1, 3'd2);
    tick();
    chk("r0_done_data", done_data, 32'd8);
    chk("r0_err", {31'd0, done_err}, 32'd0);
    tick();
    dbg("r0_zero", 3'd0, 32'd0);

    // Host write colliding with WB write
    issue(3'b010, 3'd3, 3'd1, 3'd2);
    tick();
    host_we = 1'b1; host_waddr = 3'd3; host_wdata = 32'hAA;
    tick();
    host_we = 1'b0;
    dbg("wb_wins_r3", 3'd3, 32'd8);

    // Reset during EXEC aborts
    issue(3'b010, 3'd7, 3'd1, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("abort_done", {31'd0, done}, 32'd0);
    dbg("abort_r1", 3'd1, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_after", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    dbg("abort_r7", 3'd7, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      instr_valid = $urandom_range(0, 2) != 0;
      instr_op    = 3'($urandom_range(0, 7));
      instr_rd    = 3'($urandom_range(0, 7));
      instr_rs    = 3'($urandom_range(0, 7));
      instr_rt    = 3'($urandom_range(0, 7));
      host_we     = $urandom_range(0, 3) == 0;
      host_waddr  = 3'($urandom_range(0, 7));
      host_wdata  = (($urandom_range(0, 1)) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
      dbg_addr    = 3'($urandom_range(0, 7));
      tick();
    end
    rst_n = 1'b1; instr_valid = 1'b0; host_we = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: N, 32, datapath width; must match the ALU width.
REQ-002 Parameter: REGS, 8, register-file depth; address width AW = clog2(REGS) = 3.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr_ready  output  1  instruction accepted when valid&ready at rising edge.
REQ-008 instr_op  input  3  ALU opcode, same encoding as ALUop.
REQ-009 instr_rd / instr_rs / instr_rt  input  AW each  dest / operand-A / operand-B register.
REQ-010 alu_r2 / alu_r3  output  N each  operands driven to ALU r2 / r3.
REQ-011 alu_op  output  3  opcode driven to ALU ALUop.
REQ-012 alu_r1  input  N  combinational ALU result.
REQ-013 done  output  1  one-cycle pulse: instruction retired.
REQ-014 done_err  output  1  qualifies done: opcode 3'b111 rejected.
REQ-015 done_rd / done_data  output  AW / N  retired destination and written value.
REQ-016 host_we, host_waddr, host_wdata  input  1 / AW / N  host register write.
REQ-017 dbg_addr  input  AW;  dbg_data  output  N  combinational register read.

Function
REQ-018 Register file: REGS x N flops; reg 0 SHALL read zero, writes to reg 0 SHALL be discarded.
REQ-019 FSM states: IDLE, EXEC, WB; instr_ready = 1 in IDLE and WB, 0 in EXEC and while rst_n = 0.
REQ-020 IDLE + handshake -> EXEC: latch op, rd, and read values of rs/rt into operand registers.
REQ-021 EXEC: alu_r2/alu_r3/alu_op driven from operand registers; alu_r1 captured into result register at end of cycle -> WB.
REQ-022 WB: result written to rd (unless op = 3'b111 or rd = 0); done = 1, done_rd = rd, done_data = result (0 when done_err).
REQ-023 WB + handshake -> EXEC (back-to-back); WB without handshake -> IDLE.
REQ-024 Latency: instruction accepted at edge k SHALL retire with done high in cycle k+2; peak throughput one instruction per 2 cycles.
REQ-025 Forwarding: instruction accepted in WB whose rs or rt equals the retiring rd (rd != 0, no err) SHALL latch the retiring result, not the stale register.
REQ-026 Opcode 3'b111: ALU output ignored, no register write, done_err = 1 in WB.
REQ-027 Host write: applied at any edge in any state; if same address as a WB write in the same cycle, WB write SHALL win.
REQ-028 Host write to a register read by an instruction accepted the same cycle: operand SHALL take host_wdata (forwarding below WB priority).
REQ-029 alu_r2/alu_r3/alu_op SHALL hold last values outside EXEC (no glitch-driven requirement on ALU).
REQ-030 done, done_err SHALL be 0 in every state other than WB.

Reset
REQ-031 While rst_n = 0 at an edge: state -> IDLE, all registers, operand/result registers, alu_* outputs, done, done_err, done_rd, done_data -> 0.
REQ-032 Reset asserted in EXEC or WB SHALL abort: no register write, no done pulse.
REQ-033 Host writes and handshakes during reset SHALL be ignored.
REQ-034 instr_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-035 Host-write r1=5, r2=3; issue ADD(3'b010) rd=3, rs=1, rt=2 at edge k -> done in cycle k+2, done_data=8, dbg r3=8.
REQ-036 r1=5, r2=3; SUB(3'b011) rd=4 then SLT(3'b110) rd=5 rs=2 rt=1 back-to-back -> r4=2, r5=1, done pulses at k+2 and k+4.
REQ-037 Forwarding: ADD rd=3 (r1=5,r2=3) then, accepted in its WB, ADD rd=6 rs=3 rt=3 -> r6=16.
REQ-038 Op 3'b111 rd=2 -> done=1, done_err=1, done_data=0, r2 unchanged; write to rd=0 -> r0 reads 0.
REQ-039 Host write r3=0xAA in the WB cycle of ADD rd=3 result 8 -> r3=8 (WB wins).
REQ-040 rst_n low during EXEC -> no done pulse, all registers 0, instr_ready=1 one cycle after release.
